// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: serial word stream in, parallel frame out.
interface tdm_demux_if #(
  parameter int NUM_CH = 4,
  parameter int W      = 8
);
  localparam int CW = $clog2(NUM_CH);

  logic                in_valid;
  logic [W-1:0]        in_data;
  logic                in_sof;
  logic [NUM_CH*W-1:0] out_data;
  logic                out_valid;
  logic [CW-1:0]       ch_sel;
  logic                locked;
  logic                frame_err;

  modport master (
    output in_valid, in_data, in_sof,
    input  out_data, out_valid, ch_sel, locked, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_sof,
    output out_data, out_valid, ch_sel, locked, frame_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: rebuilds NUM_CH interleaved channels into a frame
// held in a shadow buffer and publishes only complete frames.
module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       ch_sel, ch_n;
  logic [W-1:0]        shadow [NUM_CH];
  logic [NUM_CH*W-1:0] out_q, frame_n;
  logic                out_valid_q, frame_err_q;
  logic                wr_en, complete, err;
  logic [CW-1:0]       wr_idx;

  always_comb begin
    state_n  = state;
    ch_n     = ch_sel;
    wr_en    = 1'b0;
    wr_idx   = ch_sel;
    complete = 1'b0;
    err      = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        HUNT: begin
          if (bus.in_sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            ch_n    = CW'(1);
            state_n = RUN;
          end
        end
        RUN: begin
          if (ch_sel != '0 && !bus.in_sof) begin
            wr_en = 1'b1;
            if (ch_sel == LAST) begin
              complete = 1'b1;
              ch_n     = '0;
            end else begin
              ch_n = ch_sel + CW'(1);
            end
          end else if (bus.in_sof) begin
            // An early SOF resyncs on the spot rather than dropping back to HUNT.
            err    = (ch_sel != '0);
            wr_en  = 1'b1;
            wr_idx = '0;
            ch_n   = CW'(1);
          end else begin
            err     = 1'b1;
            ch_n    = '0;
            state_n = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // The final channel word goes straight into the published frame.
  always_comb begin
    frame_n = '0;
    for (int k = 0; k < NUM_CH - 1; k++) frame_n[k*W +: W] = shadow[k];
    frame_n[(NUM_CH-1)*W +: W] = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      ch_sel      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
    end else begin
      state       <= state_n;
      ch_sel      <= ch_n;
      out_valid_q <= complete;
      frame_err_q <= err;
      if (wr_en) shadow[wr_idx] <= bus.in_data;
      if (complete) out_q <= frame_n;
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ch_sel    = ch_sel;
  assign bus.locked    = (state == RUN);
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frame scenarios plus random traffic against a
// frame-list reference model.
module tb_tdm_demux;
  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int CW     = $clog2(NUM_CH);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  // Reference model: words gathered since the last SOF, plus published state.
  logic [W-1:0]        m_frame [$];
  logic [NUM_CH*W-1:0] m_data;
  bit                  m_valid, m_err, m_locked;

  tdm_demux_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

  tdm_demux #(.NUM_CH(NUM_CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_frame.delete();
    m_data   = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_locked = 1'b0;
  endtask

  task automatic send(input bit v, input bit s, input logic [W-1:0] d);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_frame  = {d};
          m_locked = 1'b1;
        end
      end else if (s) begin
        m_err   = (m_frame.size() != 0);
        m_frame = {d};
      end else if (m_frame.size() == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == NUM_CH) begin
          for (int k = 0; k < NUM_CH; k++) m_data[k*W +: W] = m_frame[k];
          m_valid = 1'b1;
          m_frame.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b0, W'($urandom));
      checks++;
      if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.locked !== 1'b0 ||
          bus.ch_sel !== '0 || bus.frame_err !== 1'b0)
        $display("[TB] FAIL reset_idle cyc%0d: got data=%h v=%b lk=%b ch=%0d err=%b, need all zero",
                 i, bus.out_data, bus.out_valid, bus.locked, bus.ch_sel, bus.frame_err);
      else passed++;
    end
  endtask

  task automatic test_basic_frame();
    logic [W-1:0]  words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [CW-1:0] chs   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send(1'b1, i == 0, words[i]);
      checks++;
      if (bus.ch_sel !== chs[i] || bus.locked !== 1'b1 || bus.out_valid !== (i == 3) ||
          bus.out_data !== m_data || bus.frame_err !== 1'b0)
        $display("[TB] FAIL basic_frame w%0d: got ch=%0d lk=%b v=%b data=%h, need ch=%0d lk=1 v=%b data=%h",
                 i, bus.ch_sel, bus.locked, bus.out_valid, bus.out_data, chs[i], i == 3, m_data);
      else passed++;
    end
    checks++;
    if (bus.out_data !== 32'h44332211)
      $display("[TB] FAIL basic_data: got %h need 44332211", bus.out_data);
    else passed++;
    send(1'b0, 1'b0, '0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h44332211)
      $display("[TB] FAIL basic_pulse_end: got v=%b data=%h need v=0 data=44332211",
               bus.out_valid, bus.out_data);
    else passed++;
  endtask

  task automatic test_gapped_frame();
    logic [W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      send(i % 2 == 0, i == 0, (i % 2 == 0) ? words[i/2] : 8'hEE);
      if (bus.out_valid) pulses++;
      checks++;
      if (bus.ch_sel !== CW'(m_frame.size()) || bus.out_valid !== m_valid ||
          bus.out_data !== m_data || bus.locked !== m_locked)
        $display("[TB] FAIL gapped_frame c%0d: got ch=%0d v=%b data=%h lk=%b, need ch=%0d v=%b data=%h lk=%b",
                 i, bus.ch_sel, bus.out_valid, bus.out_data, bus.locked,
                 m_frame.size(), m_valid, m_data, m_locked);
      else passed++;
    end
    checks++;
    if (pulses != 1 || bus.out_data !== 32'h44332211)
      $display("[TB] FAIL gapped_result: got pulses=%0d data=%h need 1 and 44332211", pulses, bus.out_data);
    else passed++;
  endtask

  task automatic test_early_sof();
    logic [W-1:0] words [6] = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    bit           sofs  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int errs = 0;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, sofs[i], words[i]);
      if (bus.frame_err) errs++;
      checks++;
      if (bus.frame_err !== (i == 2) || bus.out_valid !== (i == 5) || bus.out_data !== m_data ||
          bus.locked !== 1'b1 || bus.ch_sel !== CW'(m_frame.size()))
        $display("[TB] FAIL early_sof w%0d: got err=%b v=%b data=%h lk=%b ch=%0d, need err=%b v=%b data=%h lk=1 ch=%0d",
                 i, bus.frame_err, bus.out_valid, bus.out_data, bus.locked, bus.ch_sel,
                 i == 2, i == 5, m_data, m_frame.size());
      else passed++;
    end
    checks++;
    if (errs != 1 || bus.out_data !== 32'hB4B3B2B1)
      $display("[TB] FAIL early_sof_result: got errs=%0d data=%h need 1 and b4b3b2b1", errs, bus.out_data);
    else passed++;
  endtask

  task automatic test_missing_sof();
    logic [W-1:0] words [11] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                                 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 11; i++) begin
      send(1'b1, i == 0 || i == 7, words[i]);
      checks++;
      if (bus.frame_err !== m_err || bus.locked !== m_locked || bus.out_valid !== m_valid ||
          bus.out_data !== m_data || bus.ch_sel !== CW'(m_frame.size()))
        $display("[TB] FAIL missing_sof w%0d: got err=%b lk=%b v=%b data=%h ch=%0d, need err=%b lk=%b v=%b data=%h ch=%0d",
                 i, bus.frame_err, bus.locked, bus.out_valid, bus.out_data, bus.ch_sel,
                 m_err, m_locked, m_valid, m_data, m_frame.size());
      else passed++;
      if (i == 4) begin
        checks++;
        if (bus.frame_err !== 1'b1 || bus.locked !== 1'b0)
          $display("[TB] FAIL missing_sof_drop: got err=%b lk=%b need err=1 lk=0", bus.frame_err, bus.locked);
        else passed++;
      end
    end
    checks++;
    if (bus.out_data !== 32'h04030201)
      $display("[TB] FAIL missing_sof_result: got %h need 04030201", bus.out_data);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    send(1'b1, 1'b1, 8'hC1);
    send(1'b1, 1'b0, 8'hC2);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.locked !== 1'b0 ||
        bus.ch_sel !== '0 || bus.frame_err !== 1'b0)
      $display("[TB] FAIL mid_reset_async: got data=%h v=%b lk=%b ch=%0d err=%b, need all zero",
               bus.out_data, bus.out_valid, bus.locked, bus.ch_sel, bus.frame_err);
    else passed++;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1'b1, 1'b0, 8'hC3);
    if (bus.out_valid) pulses++;
    send(1'b1, 1'b0, 8'hC4);
    if (bus.out_valid) pulses++;
    checks++;
    if (pulses != 0 || bus.locked !== 1'b0 || bus.out_data !== '0)
      $display("[TB] FAIL mid_reset_tail: got pulses=%0d lk=%b data=%h need 0, 0, 0",
               pulses, bus.locked, bus.out_data);
    else passed++;
  endtask

  task automatic test_random();
    bit v, s;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 5) != 0;
      s = (m_frame.size() == 0) ? (($urandom % 8) != 0) : (($urandom % 12) == 0);
      send(v, s, W'($urandom));
      checks++;
      if (bus.out_data !== m_data || bus.out_valid !== m_valid || bus.frame_err !== m_err ||
          bus.locked !== m_locked || bus.ch_sel !== CW'(m_frame.size()) ||
          (bus.out_valid && bus.frame_err))
        $display("[TB] FAIL random c%0d: got data=%h v=%b err=%b lk=%b ch=%0d, need data=%h v=%b err=%b lk=%b ch=%0d",
                 i, bus.out_data, bus.out_valid, bus.frame_err, bus.locked, bus.ch_sel,
                 m_data, m_valid, m_err, m_locked, m_frame.size());
      else passed++;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic_frame();
    test_gapped_frame();
    test_early_sof();
    test_missing_sof();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer. Takes one narrow word stream carrying NUM_CH interleaved channels, marked by a start-of-frame flag, and fans it back out to NUM_CH parallel channel registers.
- It is the receive-side counterpart of the mux-based channel selectors in the datapath: the channel index is regenerated by a counter instead of driven by an external select.
- Complete frames are presented atomically through a shadow buffer, with a one-cycle valid pulse.

Parameters:
- NUM_CH, 4, number of interleaved channels per frame; legal range 2..16.
- W, 8, width of each channel word in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sof qualify this cycle; a word is accepted only when high.
- in_data  input  W  channel word.
- in_sof  input  1  high with the word belonging to channel 0.
- out_data  output  NUM_CH*W  last complete frame; channel k occupies bits [k*W +: W].
- out_valid  output  1  one-cycle pulse: out_data has just been updated.
- ch_sel  output  $clog2(NUM_CH)  channel index the next accepted word will be written to.
- locked  output  1  high while in RUN.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, rst_n=0), all outputs and state cleared:
  - state=HUNT, ch_sel=0, locked=0.
  - out_valid=0, frame_err=0.
  - out_data=0, shadow buffer=0.
- Cycles with in_valid=0: no state change, no counter change, and out_valid/frame_err deassert.
- HUNT (accepted word):
  - in_sof=1: write the word to shadow[0], set ch_sel=1, go to RUN. locked is high the following cycle.
  - in_sof=0: discard the word and stay in HUNT. No frame_err is raised in HUNT.
- RUN (accepted word), with idx = current ch_sel:
  - idx!=0 and in_sof=0: write shadow[idx].
    - If idx=NUM_CH-1, the frame completes: ch_sel wraps to 0; next cycle out_data shows shadow[0..NUM_CH-2] plus this word, and out_valid=1 for exactly one cycle.
    - Otherwise ch_sel=idx+1.
  - idx=0 and in_sof=1: normal frame start; write shadow[0], ch_sel=1.
  - idx!=0 and in_sof=1 (early SOF): frame_err pulse next cycle. The partial frame is discarded and out_data is unchanged. The word is written to shadow[0], ch_sel=1, and the block stays in RUN (immediate resync).
  - idx=0 and in_sof=0 (missing SOF): frame_err pulse next cycle. The word is discarded, ch_sel=0, state goes to HUNT, locked=0 next cycle.
- Latency: out_valid rises on the clock edge that accepts the last channel word. It is visible in the cycle after the in_valid cycle carrying channel NUM_CH-1.
- out_data holds its value between frames and only changes on out_valid. There are no partial updates.
- Back-to-back frames (in_valid held high) give an out_valid pulse every NUM_CH cycles, with no bubble.
- out_valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame returns to the reset state immediately; the partial frame is lost.
- Shadow entries are not cleared between frames; they are overwritten. This is invisible, because only complete frames reach out_data.

Test Plan:
- Reset, then in_valid=0 for 5 cycles -> out_data=0, out_valid=0, locked=0, ch_sel=0 throughout.
- NUM_CH=4, W=8: send words 0x11(sof),0x22,0x33,0x44 on consecutive cycles -> in the next cycle out_data=0x44332211 and out_valid is one pulse; locked is high from the 2nd cycle; ch_sel sequence is 0,1,2,3,0.
- Same frame with in_valid=0 inserted between every word -> same out_data=0x44332211, one out_valid pulse, ch_sel frozen during gaps.
- After a good frame, send 0xA1(sof),0xA2,0xB1(sof),0xB2,0xB3,0xB4 -> one frame_err pulse after 0xB1; out_data stays 0x44332211 until it changes to 0xB4B3B2B1 with out_valid.
- After a good frame, send 0x55 with in_sof=0 at ch_sel=0 -> frame_err pulse, locked=0. Then 0x66,0x77 with sof=0 are ignored, and a new sof frame 0x01..0x04 gives out_data=0x04030201.
- Assert rst_n=0 for one cycle after 2 words of a frame -> all outputs return to 0 asynchronously. The remaining 2 words with sof=0 produce no out_valid.
